seq_detect_scheduler: RTL and testbench

//   Time-shares one "1011" overlapping sequence-detector FSM between NCH serial
//   bit-stream channels. Each channel keeps its own saved detector state. A

---
 rtl/seq_detect_scheduler.sv | 129 ++++++++++++
 tb/tb_seq_detect_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
// One "1011" overlapping sequence detector shared round-robin between NCH
// serial channels. Each channel has its own saved detector state, and at most
// one bit is accepted per cycle. Every match is reported with its channel
// number and added to a saturating running total.
//
// state | meaning
// S0    | nothing useful seen yet
// S1    | last bit was 1
// S10   | last bits were 1,0
// S101  | last bits were 1,0,1
// S1011 | full match just completed (overlap allowed)
module seq_detect_scheduler #(
    parameter int NCH  = 4,
    parameter int CW   = 2,
    parameter int CNTW = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    bit_valid,
    input  logic [NCH-1:0]    bit_in,
    output logic [NCH-1:0]    bit_ready,
    input  logic [NCH-1:0]    chan_clear,
    output logic              det_valid,
    output logic [CW-1:0]     det_ch,
    output logic [CNTW-1:0]   match_count
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t            chan_state_q [NCH];
    logic [CW-1:0]     ptr_q, ptr_d;
    logic              det_valid_q, det_valid_d;
    logic [CW-1:0]     det_ch_q, det_ch_d;
    logic [CNTW-1:0]   match_count_q, match_count_d;

    logic [NCH-1:0]    grant;
    logic              grant_any;
    logic [CW-1:0]     grant_idx;
    state_t            cur_state;
    state_t            nxt_state;
    logic              cur_bit;
    logic              match_hit;

    // Round-robin grant: first valid channel at or after the pointer, wrapping.
    always_comb begin : p_grant
        int cand;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int off = 0; off < NCH; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NCH) cand = cand - NCH;
            if (!grant_any && bit_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_any   = 1'b1;
                grant_idx   = CW'(cand);
            end
        end
    end

    assign bit_ready = grant;

    // Shared detector transition for the granted channel; unknown encodings fall back to S0.
    always_comb begin
        cur_state = chan_state_q[grant_idx];
        cur_bit   = bit_in[grant_idx];
        nxt_state = S0;
        case (cur_state)
            S0:      nxt_state = cur_bit ? S1    : S0;
            S1:      nxt_state = cur_bit ? S1    : S10;
            S10:     nxt_state = cur_bit ? S101  : S0;
            S101:    nxt_state = cur_bit ? S1011 : S10;
            S1011:   nxt_state = cur_bit ? S1    : S10;
            default: nxt_state = S0;
        endcase
    end

    // Match detection, pointer advance and saturating counter next values.
    always_comb begin
        // A clear on the granted channel swallows the bit without reporting it.
        match_hit   = grant_any && !chan_clear[grant_idx] && (nxt_state == S1011);
        ptr_d       = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end
        det_valid_d   = match_hit;
        det_ch_d      = match_hit ? grant_idx : det_ch_q;
        match_count_d = match_count_q;
        if (match_hit && (match_count_q != {CNTW{1'b1}})) begin
            match_count_d = match_count_q + 1'b1;
        end
    end

    // Saved per-channel detector states and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) chan_state_q[i] <= S0;
            ptr_q         <= '0;
            det_valid_q   <= 1'b0;
            det_ch_q      <= '0;
            match_count_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (chan_clear[i]) begin
                    chan_state_q[i] <= S0;
                end else if (grant[i]) begin
                    chan_state_q[i] <= nxt_state;
                end
            end
            ptr_q         <= ptr_d;
            det_valid_q   <= det_valid_d;
            det_ch_q      <= det_ch_d;
            match_count_q <= match_count_d;
        end
    end

    assign det_valid   = det_valid_q;
    assign det_ch      = det_ch_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: a default instance (NCH=4, CNTW=16)
// and a narrow-counter instance (CNTW=3) for saturation.
module tb_seq_detect_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [3:0]  bit_valid  = '0;
    logic [3:0]  bit_in     = '0;
    logic [3:0]  chan_clear = '0;
    logic [3:0]  bit_ready;
    logic        det_valid;
    logic [1:0]  det_ch;
    logic [15:0] match_count;

    logic [3:0]  s_valid = '0;
    logic [3:0]  s_bit   = '0;
    logic [3:0]  s_clear = '0;
    logic [3:0]  s_ready;
    logic        s_det;
    logic [1:0]  s_ch;
    logic [2:0]  s_count;

    int checks   = 0;
    int failures = 0;

    seq_detect_scheduler #(.NCH(4), .CW(2), .CNTW(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .bit_ready   (bit_ready),
        .chan_clear  (chan_clear),
        .det_valid   (det_valid),
        .det_ch      (det_ch),
        .match_count (match_count)
    );

    seq_detect_scheduler #(.NCH(4), .CW(2), .CNTW(3)) dut_s (
        .clock       (clock),
        .reset       (reset),
        .bit_valid   (s_valid),
        .bit_in      (s_bit),
        .bit_ready   (s_ready),
        .chan_clear  (s_clear),
        .det_valid   (s_det),
        .det_ch      (s_ch),
        .match_count (s_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bit_valid  = '0;
        bit_in     = '0;
        chan_clear = '0;
        s_valid    = '0;
        s_bit      = '0;
        s_clear    = '0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Present one bit on a lone channel for one cycle, then check the pulse.
    task automatic send(input int ch, input logic b, input logic clr,
                        input logic expdet, input string tag);
        bit_valid  = '0;
        bit_in     = '0;
        chan_clear = '0;
        bit_valid[ch]  = 1'b1;
        bit_in[ch]     = b;
        chan_clear[ch] = clr;
        #1;
        chk({tag, "_ready"}, 32'(bit_ready), 32'(1) << ch);
        @(posedge clock); #1;
        bit_valid  = '0;
        bit_in     = '0;
        chan_clear = '0;
        chk({tag, "_det"}, 32'(det_valid), 32'(expdet));
    endtask

    // Send n bits (MSB-first within the low n bits) with expected pulse pattern.
    task automatic run_bits(input int ch, input logic [15:0] bits, input logic [15:0] expd,
                            input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            send(ch, bits[n-1-k], 1'b0, expd[n-1-k], tag);
        end
    endtask

    task automatic send_s(input logic b, input logic expdet);
        s_valid = 4'b0001;
        s_bit   = {3'b000, b};
        @(posedge clock); #1;
        s_valid = '0;
        s_bit   = '0;
        chk("t6_det", 32'(s_det), 32'(expdet));
    endtask

    initial begin
        logic [3:0] seq;
        logic [3:0] g;
        int i0, i1, m, pulses;

        do_reset();

        // Reset state
        chk("rst_det_valid", 32'(det_valid), 32'd0);
        chk("rst_det_ch", 32'(det_ch), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        #1;
        chk("rst_ready_none", 32'(bit_ready), 32'd0);
        bit_valid = 4'b1111;
        #1;
        chk("rst_ready_all", 32'(bit_ready), 32'd1);
        bit_valid = '0;
        @(posedge clock); #1;

        // Test 1: ch0 1,0,1,1,0,1,1 -> pulses after bits 4 and 7
        run_bits(0, 16'b1011011, 16'b0001001, 7, "t1");
        chk("t1_det_ch", 32'(det_ch), 32'd0);
        chk("t1_count", 32'(match_count), 32'd2);

        // Test 2: ch0 and ch1 contend, grants alternate
        do_reset();
        seq = 4'b1011;
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            bit_valid = '0;
            bit_in    = '0;
            if (i0 < 4) begin bit_valid[0] = 1'b1; bit_in[0] = seq[3-i0]; end
            if (i1 < 4) begin bit_valid[1] = 1'b1; bit_in[1] = seq[3-i1]; end
            #1;
            chk("t2_grant", 32'(bit_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
            g = bit_ready;
            @(posedge clock); #1;
            if (g[0]) i0++;
            if (g[1]) i1++;
            chk("t2_det", 32'(det_valid), (c >= 6) ? 32'd1 : 32'd0);
            if (c == 6) chk("t2_det_ch0", 32'(det_ch), 32'd0);
        end
        chk("t2_det_ch1", 32'(det_ch), 32'd1);
        chk("t2_count", 32'(match_count), 32'd2);
        bit_valid = '0;
        @(posedge clock); #1;
        chk("t2_idle_det", 32'(det_valid), 32'd0);
        chk("t2_det_ch_hold", 32'(det_ch), 32'd1);
        // Pointer now 2: ch0/ch1 request wraps around to ch0
        bit_valid = 4'b0011;
        #1;
        chk("t2_wrap", 32'(bit_ready), 32'd1);
        bit_valid = 4'b1001;
        #1;
        chk("t2_skip", 32'(bit_ready), 32'd8);
        bit_valid = '0;
        @(posedge clock); #1;

        // Test 3: clear collides with the completing 1 on ch2
        do_reset();
        run_bits(2, 16'b101, 16'b000, 3, "t3a");
        send(2, 1'b1, 1'b1, 1'b0, "t3_clr");
        chk("t3_count_clr", 32'(match_count), 32'd0);
        run_bits(2, 16'b1011, 16'b0001, 4, "t3b");
        chk("t3_det_ch", 32'(det_ch), 32'd2);
        chk("t3_count", 32'(match_count), 32'd1);

        // Test 4: non-matching runs on ch3; probe the saved state afterwards
        do_reset();
        run_bits(3, 16'b10011, 16'b00000, 5, "t4a");
        run_bits(3, 16'b011, 16'b001, 3, "t4_probe_s1");
        do_reset();
        run_bits(3, 16'b10011, 16'b00000, 5, "t4a2");
        run_bits(3, 16'b1010, 16'b0000, 4, "t4b");
        run_bits(3, 16'b11, 16'b01, 2, "t4_probe_s10");
        chk("t4_count", 32'(match_count), 32'd1);

        // Test 5: reset mid-stream on ch1
        do_reset();
        run_bits(1, 16'b101101, 16'b000100, 6, "t5a");
        chk("t5_pre_count", 32'(match_count), 32'd1);
        chk("t5_pre_det_ch", 32'(det_ch), 32'd1);
        bit_valid = 4'b0010;
        bit_in    = 4'b0010;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_count", 32'(match_count), 32'd0);
        chk("t5_async_det_ch", 32'(det_ch), 32'd0);
        chk("t5_async_det", 32'(det_valid), 32'd0);
        @(posedge clock); #1;
        chk("t5_held_det", 32'(det_valid), 32'd0);
        reset = 1'b0;
        bit_valid = 4'b0011;
        bit_in    = 4'b0000;
        #1;
        chk("t5_ptr_reset", 32'(bit_ready), 32'd1);
        send(1, 1'b1, 1'b0, 1'b0, "t5_single");
        chk("t5_count", 32'(match_count), 32'd0);

        // Test 6: 3-bit counter saturates at 7 while pulses continue
        do_reset();
        m = 0;
        pulses = 0;
        send_s(1'b1, 1'b0);
        send_s(1'b0, 1'b0);
        send_s(1'b1, 1'b0);
        send_s(1'b1, 1'b1);
        m = 1;
        pulses += int'(s_det);
        chk("t6_count", 32'(s_count), 32'd1);
        for (int r = 0; r < 9; r++) begin
            send_s(1'b0, 1'b0);
            send_s(1'b1, 1'b0);
            send_s(1'b1, 1'b1);
            m++;
            pulses += int'(s_det);
            chk("t6_count", 32'(s_count), (m > 7) ? 32'd7 : 32'(m));
        end
        chk("t6_pulses", 32'(pulses), 32'd10);
        chk("t6_final_count", 32'(s_count), 32'd7);
        chk("t6_det_ch", 32'(s_ch), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
